// File: rtl/demux_1x4_tdm_pkg.sv
// ----------------------------------------------------------------------------
// demux_pkg
//   Shared definitions for the 1-to-4 time-division demultiplexer.
//   - lane index constants (a=0, b=1, c=2, d=3) and lane count
//   - lane_t: 2-bit lane index type used by the slot counter and top
//   - lane_onehot(): decodes a lane index into a one-hot write enable
// ----------------------------------------------------------------------------
package demux_pkg;

  localparam int NUM_LANES = 4;

  typedef logic [1:0] lane_t;

  localparam lane_t LANE_A = 2'd0;
  localparam lane_t LANE_B = 2'd1;
  localparam lane_t LANE_C = 2'd2;
  localparam lane_t LANE_D = 2'd3;

  // Bit i of the result is set when idx selects lane i.
  function automatic logic [NUM_LANES-1:0] lane_onehot(input lane_t idx);
    logic [NUM_LANES-1:0] oh;
    oh = '0;
    case (idx)
      LANE_A:  oh[0] = 1'b1;
      LANE_B:  oh[1] = 1'b1;
      LANE_C:  oh[2] = 1'b1;
      default: oh[3] = 1'b1;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/demux_1x4_tdm_if.sv
// ----------------------------------------------------------------------------
// demux_1x4_tdm_if
//   Bundles the sample stream, lane-select controls and recovered lane
//   outputs of the demultiplexer.
//   Upstream -> demux : din, din_valid, sel, auto_mode, sync_clr
//   Demux -> downstream: a, b, c, d, valid_a..valid_d, frame_done, slot
//   Modports: master (the side feeding samples and observing lanes),
//             slave  (the demultiplexer itself).
// ----------------------------------------------------------------------------
interface demux_1x4_tdm_if #(
  parameter int WIDTH = 1
);
  import demux_pkg::*;

  logic [WIDTH-1:0] din;
  logic             din_valid;
  lane_t            sel;
  logic             auto_mode;
  logic             sync_clr;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic             valid_a;
  logic             valid_b;
  logic             valid_c;
  logic             valid_d;
  logic             frame_done;
  lane_t            slot;

  modport master (
    output din, din_valid, sel, auto_mode, sync_clr,
    input  a, b, c, d, valid_a, valid_b, valid_c, valid_d, frame_done, slot
  );

  modport slave (
    input  din, din_valid, sel, auto_mode, sync_clr,
    output a, b, c, d, valid_a, valid_b, valid_c, valid_d, frame_done, slot
  );

endinterface

// File: rtl/demux_1x4_tdm_slot_ctr.sv
// ----------------------------------------------------------------------------
// demux_slot_ctr
//   Round-robin slot counter for auto-mode lane selection.
//   Ports:
//     clk, rst    clock, synchronous active-high reset
//     en          advance request (an auto-mode sample is present)
//     clr         frame realignment: treat the current slot as lane a
//     slot        registered counter value
//     eff_slot    slot the current sample targets (lane a while clr is high)
//     last_slot   current sample targets lane d, i.e. it closes a frame
// ----------------------------------------------------------------------------
module demux_slot_ctr
  import demux_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  logic  clr,
  output lane_t slot,
  output lane_t eff_slot,
  output logic  last_slot
);

  lane_t slot_q;
  lane_t slot_d;

  // A realignment pulse makes the current sample land on lane a, so the
  // counter must already point past it when that sample is consumed.
  always_comb begin
    eff_slot  = clr ? LANE_A : slot_q;
    last_slot = (eff_slot == LANE_D);
  end

  // Realignment wins over advancing; without a request the count is frozen
  // rather than cleared so that a manual-mode interlude resumes in place.
  always_comb begin
    slot_d = slot_q;
    if (clr && en) begin
      slot_d = LANE_B;
    end else if (clr) begin
      slot_d = LANE_A;
    end else if (en) begin
      slot_d = slot_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= LANE_A;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot = slot_q;

endmodule

// File: rtl/demux_1x4_tdm.sv
// ----------------------------------------------------------------------------
// demux_1x4_tdm
//   Registered 1-to-4 time-division demultiplexer. Each valid input sample
//   is written into one of four held lanes, chosen either by an explicit
//   select or by an internal round-robin slot counter. One-cycle strobes
//   report which lane was updated, and frame_done marks the close of an
//   auto-mode frame (write to lane d).
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset, dominant over all inputs
//     bus   demux_1x4_tdm_if.slave: sample input, controls, lane outputs
//   Every output is taken straight from a flop.
// ----------------------------------------------------------------------------
module demux_1x4_tdm
  import demux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input logic            clk,
  input logic            rst,
  demux_1x4_tdm_if.slave bus
);

  lane_t                  slot;
  lane_t                  eff_slot;
  logic                   last_slot;
  logic                   ctr_en;

  lane_t                  target;
  logic [NUM_LANES-1:0]   wr_en;
  logic                   frame_end;

  logic [WIDTH-1:0]       lane_q [NUM_LANES];
  logic [NUM_LANES-1:0]   valid_q;
  logic                   frame_done_q;

  // The counter only advances on auto-mode samples; in manual mode it is
  // left frozen so that returning to auto resumes mid-frame.
  assign ctr_en = bus.auto_mode & bus.din_valid;

  demux_slot_ctr u_slot_ctr (
    .clk       (clk),
    .rst       (rst),
    .en        (ctr_en),
    .clr       (bus.sync_clr),
    .slot      (slot),
    .eff_slot  (eff_slot),
    .last_slot (last_slot)
  );

  // Lane decode. sel is only looked at in manual mode, so an unknown sel
  // during auto mode never reaches the write enables.
  always_comb begin
    target    = bus.auto_mode ? eff_slot : bus.sel;
    wr_en     = bus.din_valid ? lane_onehot(target) : '0;
    frame_end = bus.din_valid & bus.auto_mode & last_slot;
  end

  // Lane registers hold until their own lane is targeted; the strobes are
  // simply the registered write enables, hence mutually exclusive.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        lane_q[i] <= '0;
      end
      valid_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (wr_en[i]) begin
          lane_q[i] <= bus.din;
        end
      end
      valid_q      <= wr_en;
      frame_done_q <= frame_end;
    end
  end

  assign bus.a          = lane_q[LANE_A];
  assign bus.b          = lane_q[LANE_B];
  assign bus.c          = lane_q[LANE_C];
  assign bus.d          = lane_q[LANE_D];
  assign bus.valid_a    = valid_q[LANE_A];
  assign bus.valid_b    = valid_q[LANE_B];
  assign bus.valid_c    = valid_q[LANE_C];
  assign bus.valid_d    = valid_q[LANE_D];
  assign bus.frame_done = frame_done_q;
  assign bus.slot       = slot;

endmodule

// File: doc/demux_1x4_tdm.md
Name: demux_1x4_tdm

Overview:
- Registered 1-to-4 time-division demultiplexer. It is the receiving end of a 4:1 selection path.
- A single input stream is distributed onto four held output lanes a, b, c, d.
- The target lane comes either from an explicit 2-bit select or from an internal round-robin slot counter.
- Sits downstream of 4:1 mux datapaths and recovers the four lanes, with per-lane strobes and a frame marker.

Parameters:
- WIDTH, 1, bit width of din and of each output lane.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset. One clock; reset is synchronous and active-high.
- din  input  WIDTH  sample to route.
- din_valid  input  1  sample present this cycle.
- sel  input  2  explicit lane select: 00=a, 01=b, 10=c, 11=d. Used only when auto_mode=0.
- auto_mode  input  1  1 = lane from internal slot counter; 0 = lane from sel.
- sync_clr  input  1  forces the slot counter to lane a (frame realignment).
- a, b, c, d  output  WIDTH  held lane values.
- valid_a, valid_b, valid_c, valid_d  output  1  one-cycle strobe: the lane was updated this cycle.
- frame_done  output  1  one-cycle strobe: lane d was written in auto mode.
- slot  output  2  current slot counter value.

Behaviour:
- Reset (rst=1 at posedge):
  - a, b, c, d = 0; all valid_* = 0; frame_done = 0; slot = 0.
  - rst has priority over every other input.
- Target lane at a cycle with din_valid=1:
  - eff_slot = 0 if sync_clr=1, else slot.
  - target = auto_mode ? eff_slot : sel.
- Latency: one cycle.
  - din sampled at edge N appears on the target lane after edge N.
  - valid_<target> = 1 for exactly that cycle.
  - Non-target lanes hold their value; their valid_* = 0.
- din_valid=0: no lane changes; all valid_* = 0; frame_done = 0.
- Slot counter:
  - Priority 1 — sync_clr=1 and din_valid=1 in auto mode: sample goes to lane a, slot becomes 1.
  - Priority 2 — sync_clr=1 otherwise: slot becomes 0.
  - Priority 3 — auto_mode=1 and din_valid=1: slot increments, wrapping 3 -> 0.
  - Otherwise: slot holds. In manual mode the counter is frozen, not cleared.
- frame_done = 1 in the cycle after an auto-mode write to lane d, coincident with valid_d. It is never asserted in manual mode.
- Mode switch:
  - auto_mode is sampled each cycle; no pipeline flush is required.
  - A 1->0 switch freezes slot.
  - A 0->1 switch resumes from the frozen slot value.
- Valid strobes are mutually exclusive; at most one valid_* is high per cycle.
- sel is ignored when auto_mode=1; X on sel in auto mode must not propagate.
- rst asserted mid-frame: lanes clear and slot returns to 0. The next auto sample goes to lane a.
- All outputs are driven directly from flops; no combinational path from any input to any output.

Decomposition:
- Shared package demux_pkg:
  - Lane index constants LANE_A=2'd0, LANE_B=2'd1, LANE_C=2'd2, LANE_D=2'd3.
  - NUM_LANES=4.
- One natural sub-module, demux_slot_ctr:
  - The 2-bit wrap counter with sync_clr, enable and freeze.
  - Emits slot and a last_slot flag used to generate frame_done.
- Top level: lane select decode, four lane registers, strobe registers.

Test Plan:
- Reset check: rst=1 for 2 cycles with din_valid=1, din=1 -> a..d=0, valid_*=0, frame_done=0, slot=0 throughout.
- Manual routing, WIDTH=1, auto_mode=0: drive sel=00/01/10/11 with din=1,0,1,1 on consecutive cycles.
  - Expect a=1, b=0, c=1, d=1.
  - Expect valid_a, valid_b, valid_c, valid_d strobing in successive cycles.
  - Expect slot to stay 0 and frame_done to stay 0.
- Auto round-robin: auto_mode=1, five back-to-back samples 1,0,0,1,0.
  - Expect a=1, b=0, c=0, d=1.
  - Expect frame_done high with valid_d.
  - The fifth sample overwrites a to 0; slot ends at 1.
- Gaps and freeze:
  - Auto mode, sample to a, then din_valid=0 for 3 cycles -> slot stays 1, all lanes hold.
  - Switch auto_mode=0 with sel=11 and din=1 -> d=1, slot still 1.
  - Switch back to auto mode -> next sample goes to b.
- sync_clr collision: slot=2, sync_clr=1 together with din_valid=1 and din=1 -> a=1, valid_a=1, slot=1, c unchanged.
- Reset mid-frame: after samples to a and b, assert rst for one cycle -> all lanes 0; next auto sample lands on a.
